// File: rtl/req_arbiter_7seg_pkg.sv
// +----------------------------------------------------------------------------+
// | req_arbiter_7seg_pkg                                                       |
// | Shared state encoding and 7-segment constants for the request arbiter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package req_arbiter_7seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // gfedcba codes, element i shows digit i
    localparam logic [7:0][6:0] SEG_LUT = {
        7'b0000111,   // 7
        7'b1111101,   // 6
        7'b1101101,   // 5
        7'b1100110,   // 4
        7'b1001111,   // 3
        7'b1011011,   // 2
        7'b0000110,   // 1
        7'b0111111    // 0
    };

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/req_arbiter_7seg_prio.sv
// +----------------------------------------------------------------------------+
// | rr_priority_encoder_8                                                      |
// | Combinational 8-way priority search starting at a given index, downward.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_priority_encoder_8 (
    input  logic [7:0] req,
    input  logic [2:0] start,
    input  logic       rr_mode,
    output logic [2:0] winner,
    output logic       any
);

    logic [2:0]  w_start;
    logic [15:0] w_dbl;
    logic [7:0]  w_rot;
    logic [2:0]  w_pos;

    assign w_start = rr_mode ? start : 3'd7;

    // Rotate so that index w_start lands on bit 7, the top of the fixed search
    assign w_dbl = {req, req} >> ({1'b0, w_start} + 4'd1);
    assign w_rot = w_dbl[7:0];

    always_comb begin
        w_pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_rot[i]) begin
                w_pos = 3'(i);
            end
        end
    end

    assign winner = w_pos + w_start + 3'd1;
    assign any    = |req;

endmodule

`default_nettype wire

// File: rtl/req_arbiter_7seg.sv
// +----------------------------------------------------------------------------+
// | req_arbiter_7seg                                                           |
// | 8-requester arbiter with hold limit, GAP cycle and 7-segment owner display.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module req_arbiter_7seg #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        req,
    input  logic              rr_mode,
    input  logic [HOLD_W-1:0] hold_limit,
    output logic [7:0]        gnt,
    output logic              gnt_valid,
    output logic [6:0]        segments,
    output logic              no_grant
);

    import req_arbiter_7seg_pkg::*;

    state_t            r_state;
    logic [2:0]        r_last_owner;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [2:0] w_start;
    logic [2:0] w_winner;
    logic       w_any;
    logic       w_others;
    logic       w_limit_hit;
    logic       w_release;

    assign w_start = r_last_owner - 3'd1;

    rr_priority_encoder_8 u_prio (
        .req     (req),
        .start   (w_start),
        .rr_mode (rr_mode),
        .winner  (w_winner),
        .any     (w_any)
    );

    // r_hold_cnt counts cycles already granted, so a limit of N allows N cycles
    assign w_others    = |(req & ~gnt);
    assign w_limit_hit = (hold_limit != '0) && (r_hold_cnt >= hold_limit) && w_others;
    assign w_release   = !req[r_last_owner] || w_limit_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_owner <= 3'd0;
            r_hold_cnt   <= '0;
            gnt          <= 8'h00;
            gnt_valid    <= 1'b0;
            segments     <= SEG_BLANK;
            no_grant     <= 1'b1;
        end else begin
            case (r_state)
                GRANT: begin
                    if (r_hold_cnt != '1) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                    if (w_release) begin
                        r_state   <= GAP;
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        segments  <= SEG_BLANK;
                        no_grant  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and GAP arbitrate identically on the sampled requests
                    if (w_any) begin
                        r_state      <= GRANT;
                        r_last_owner <= w_winner;
                        r_hold_cnt   <= HOLD_W'(1);
                        gnt          <= onehot8(w_winner);
                        gnt_valid    <= 1'b1;
                        segments     <= SEG_LUT[w_winner];
                        no_grant     <= 1'b0;
                    end else begin
                        r_state   <= IDLE;
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        segments  <= SEG_BLANK;
                        no_grant  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_req_arbiter_7seg.sv
// +----------------------------------------------------------------------------+
// | tb_req_arbiter_7seg                                                        |
// | Directed and randomized check of req_arbiter_7seg against a cycle model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_req_arbiter_7seg;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       rr_mode;
    logic [3:0] hold_limit;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [6:0] segments;
    logic       no_grant;

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner index or -1, cycles granted so far, last owner
    int m_owner;
    int m_cnt;
    int m_last;

    logic [6:0] seg_tab [8] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111};

    always #5 clk = ~clk;

    req_arbiter_7seg #(.HOLD_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .rr_mode    (rr_mode),
        .hold_limit (hold_limit),
        .gnt        (gnt),
        .gnt_valid  (gnt_valid),
        .segments   (segments),
        .no_grant   (no_grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input bit rr, input int last);
        int start;
        start = rr ? (last + 7) % 8 : 7;
        for (int k = 0; k < 8; k++) begin
            if (r[(start - k + 8) % 8]) return (start - k + 8) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 0;
    endtask

    task automatic model_step();
        logic [7:0] others;
        if (m_owner >= 0) begin
            others = req;
            others[m_owner] = 1'b0;
            if (!req[m_owner] ||
                (hold_limit != 0 && m_cnt >= int'(hold_limit) && others != 0)) begin
                m_owner = -1;
            end else if (m_cnt < 15) begin
                m_cnt++;
            end
        end else if (req != 0) begin
            m_owner = pick(req, rr_mode, m_last);
            m_last  = m_owner;
            m_cnt   = 1;
        end
    endtask

    task automatic compare_outputs();
        logic [7:0] e_gnt;
        e_gnt = 8'h00;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        check("gnt", gnt, e_gnt);
        check("gnt_valid", gnt_valid, m_owner >= 0);
        check("segments", segments, (m_owner >= 0) ? seg_tab[m_owner] : 7'b0000000);
        check("no_grant", no_grant, m_owner < 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst        = 1'b1;
        req        = 8'h00;
        rr_mode    = 1'b0;
        hold_limit = 4'd0;
        model_reset();
        ticks(2);
        rst = 1'b0;
        ticks(10);

        // Fixed priority, owner drop, GAP, next winner
        req = 8'b0010_1000;
        tick();
        check("seg5", segments, 7'b1101101);
        req = 8'b0000_1000;
        tick();
        check("gap_no_grant", no_grant, 1'b1);
        tick();
        check("gnt3", gnt, 8'b0000_1000);
        check("seg3", segments, 7'b1001111);
        req = 8'h00;
        ticks(3);

        // Round-robin forced rotation
        rr_mode    = 1'b1;
        hold_limit = 4'd3;
        req        = 8'b1000_0001;
        ticks(14);

        // Single requester outlives the limit, then yields
        hold_limit = 4'd2;
        req        = 8'b0000_0100;
        ticks(20);
        req = 8'b0100_0100;
        tick();
        check("gap_before_6", gnt, 8'h00);
        tick();
        check("seg6", segments, 7'b1111101);
        req = 8'h00;
        ticks(3);

        // Counter saturation: limit 15 must still trigger after a long hold
        hold_limit = 4'd15;
        req        = 8'b0000_0010;
        ticks(25);
        req = 8'b0000_0011;
        ticks(3);
        req = 8'h00;
        ticks(3);

        // Asynchronous reset while owner 4 holds the grant
        req = 8'b0001_0000;
        ticks(3);
        #2 rst = 1'b1;
        #1;
        check("async_gnt", gnt, 8'h00);
        check("async_no_grant", no_grant, 1'b1);
        check("async_gnt_valid", gnt_valid, 1'b0);
        tick();
        rst        = 1'b0;
        rr_mode    = 1'b1;
        hold_limit = 4'd1;
        req        = 8'hFF;
        tick();
        check("rr_first7", gnt, 8'b1000_0000);
        ticks(17);

        // Unlimited hold
        hold_limit = 4'd0;
        req        = 8'b1100_0000;
        ticks(10);
        req = 8'b0100_0000;
        ticks(4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) rr_mode = 1'($urandom);
            if ($urandom_range(0, 15) == 0) hold_limit = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            else if ($urandom_range(0, 1) == 0) req = req ^ (8'h01 << $urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
